// File: rtl/pipe_hdu.sv
// Hazard and sequencing controller for the hxd32 five-stage pipe: load-use interlock,
// DRAM wait freeze with timeout, and wrong-path flush after a taken redirect.
module pipe_hdu #(
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned WAIT_W    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_rd_addr_i,
    input  logic [4:0] id_rs2_rd_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic       ex_rd_wr_en_i,
    input  logic [1:0] ex_rd_wr_sel_i,
    input  logic [4:0] ex_rd_wr_addr_i,
    input  logic       ex_pc_wr_en_i,
    input  logic       dram_req_i,
    input  logic       dram_ack_i,
    output logic       pc_stall_o,
    output logic       ifu_stall_o,
    output logic       ifu_flush_o,
    output logic       idu_stall_o,
    output logic       idu_flush_o,
    output logic       exu_stall_o,
    output logic       mem_timeout_o,
    output logic [1:0] hazard_state_o
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StFlush   = 2'b10
    } state_e;

    localparam logic [2:0]        FlushLen = 3'(FLUSH_LEN);
    localparam logic [WAIT_W-1:0] WaitMax  = '1;
    localparam logic [WAIT_W-1:0] WaitOne  = WAIT_W'(1);

    state_e            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic load_use;
    logic mem_wait;
    logic stall_all;
    logic lu_stall;
    logic ifu_flush;
    logic idu_flush;
    logic timeout;

    assign load_use = ex_rd_wr_en_i && (ex_rd_wr_sel_i == 2'b01) && (ex_rd_wr_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_rd_addr_i == ex_rd_wr_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_rd_addr_i == ex_rd_wr_addr_i)));
    assign mem_wait = dram_req_i && !dram_ack_i;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stall_all   = 1'b0;
        lu_stall    = 1'b0;
        ifu_flush   = 1'b0;
        idu_flush   = 1'b0;
        timeout     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_wait) begin
                    stall_all  = 1'b1;
                    wait_cnt_d = WaitOne;
                    state_d    = StMemWait;
                end else if (ex_pc_wr_en_i) begin
                    ifu_flush   = 1'b1;
                    idu_flush   = 1'b1;
                    flush_cnt_d = FlushLen;
                    state_d     = (FlushLen != 3'd0) ? StFlush : StRun;
                end else if (load_use) begin
                    // Load is in MEM next cycle, so this bubble lasts exactly one cycle
                    lu_stall  = 1'b1;
                    idu_flush = 1'b1;
                end
            end

            StMemWait: begin
                // EX is frozen here, so redirect and load-use are re-evaluated after release
                if (dram_ack_i || (wait_cnt_q == WaitMax)) begin
                    timeout    = !dram_ack_i;
                    wait_cnt_d = '0;
                    state_d    = (flush_cnt_q != 3'd0) ? StFlush : StRun;
                end else begin
                    stall_all  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WaitOne;
                end
            end

            StFlush: begin
                if (mem_wait) begin
                    // flush_cnt holds so the flush resumes once DRAM completes
                    stall_all  = 1'b1;
                    wait_cnt_d = WaitOne;
                    state_d    = StMemWait;
                end else if (ex_pc_wr_en_i) begin
                    ifu_flush   = 1'b1;
                    idu_flush   = 1'b1;
                    flush_cnt_d = FlushLen;
                    state_d     = (FlushLen != 3'd0) ? StFlush : StRun;
                end else begin
                    ifu_flush = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end

            default: begin
                state_d     = StRun;
                flush_cnt_d = 3'd0;
                wait_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held, regardless of input hazards
    assign pc_stall_o     = !rst_i && (stall_all || lu_stall);
    assign ifu_stall_o    = !rst_i && (stall_all || lu_stall);
    assign ifu_flush_o    = !rst_i && ifu_flush;
    assign idu_stall_o    = !rst_i && stall_all;
    assign idu_flush_o    = !rst_i && idu_flush;
    assign exu_stall_o    = !rst_i && stall_all;
    assign mem_timeout_o  = !rst_i && timeout;
    assign hazard_state_o = state_q;

endmodule

// File: tb/tb_pipe_hdu.sv
// Directed bench for pipe_hdu (FLUSH_LEN=2, WAIT_W=2); every cycle's outputs are checked
// against a hand-computed vector.
module tb_pipe_hdu;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_rd_addr_i, id_rs2_rd_addr_i;
    logic       id_rs1_used_i, id_rs2_used_i;
    logic       ex_rd_wr_en_i;
    logic [1:0] ex_rd_wr_sel_i;
    logic [4:0] ex_rd_wr_addr_i;
    logic       ex_pc_wr_en_i, dram_req_i, dram_ack_i;
    logic       pc_stall_o, ifu_stall_o, ifu_flush_o, idu_stall_o, idu_flush_o, exu_stall_o;
    logic       mem_timeout_o;
    logic [1:0] hazard_state_o;

    int n_asserts = 0;
    int n_fail    = 0;

    // {pc_stall, ifu_stall, ifu_flush, idu_stall, idu_flush, exu_stall, mem_timeout, state}
    localparam logic [8:0] O_IDLE        = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] O_LU          = 9'b1_1_0_0_1_0_0_00;
    localparam logic [8:0] O_STALL_RUN   = 9'b1_1_0_1_0_1_0_00;
    localparam logic [8:0] O_STALL_MW    = 9'b1_1_0_1_0_1_0_01;
    localparam logic [8:0] O_STALL_FL    = 9'b1_1_0_1_0_1_0_10;
    localparam logic [8:0] O_MW_REL      = 9'b0_0_0_0_0_0_0_01;
    localparam logic [8:0] O_TIMEOUT     = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] O_REDIR_RUN   = 9'b0_0_1_0_1_0_0_00;
    localparam logic [8:0] O_REDIR_FLUSH = 9'b0_0_1_0_1_0_0_10;
    localparam logic [8:0] O_FLUSH       = 9'b0_0_1_0_0_0_0_10;

    pipe_hdu #(
        .FLUSH_LEN(2),
        .WAIT_W   (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_rs1_rd_addr_i(id_rs1_rd_addr_i),
        .id_rs2_rd_addr_i(id_rs2_rd_addr_i),
        .id_rs1_used_i   (id_rs1_used_i),
        .id_rs2_used_i   (id_rs2_used_i),
        .ex_rd_wr_en_i   (ex_rd_wr_en_i),
        .ex_rd_wr_sel_i  (ex_rd_wr_sel_i),
        .ex_rd_wr_addr_i (ex_rd_wr_addr_i),
        .ex_pc_wr_en_i   (ex_pc_wr_en_i),
        .dram_req_i      (dram_req_i),
        .dram_ack_i      (dram_ack_i),
        .pc_stall_o      (pc_stall_o),
        .ifu_stall_o     (ifu_stall_o),
        .ifu_flush_o     (ifu_flush_o),
        .idu_stall_o     (idu_stall_o),
        .idu_flush_o     (idu_flush_o),
        .exu_stall_o     (exu_stall_o),
        .mem_timeout_o   (mem_timeout_o),
        .hazard_state_o  (hazard_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {pc_stall_o, ifu_stall_o, ifu_flush_o, idu_stall_o, idu_flush_o, exu_stall_o,
               mem_timeout_o, hazard_state_o};
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs, then advance to just after the next rising edge
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, exp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1_rd_addr_i = 5'd0;
        id_rs2_rd_addr_i = 5'd0;
        id_rs1_used_i    = 1'b0;
        id_rs2_used_i    = 1'b0;
        ex_rd_wr_en_i    = 1'b0;
        ex_rd_wr_sel_i   = 2'b00;
        ex_rd_wr_addr_i  = 5'd0;
        ex_pc_wr_en_i    = 1'b0;
        dram_req_i       = 1'b0;
        dram_ack_i       = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_rd_wr_en_i    = 1'b1;
        ex_rd_wr_sel_i   = 2'b01;
        ex_rd_wr_addr_i  = rd;
        id_rs1_rd_addr_i = rd;
        id_rs1_used_i    = 1'b1;
    endtask

    // Structural invariants, sampled mid-cycle whenever reset is released
    always @(negedge clk_i) begin
        if (!rst_i) begin
            n_asserts++;
            assert (!(ifu_stall_o && ifu_flush_o) && !(idu_stall_o && idu_flush_o) &&
                    (hazard_state_o != 2'b11) && (!mem_timeout_o || hazard_state_o == 2'b01))
            else begin
                n_fail++;
                $error("FAIL invariant: observed %b%b%b%b%b st=%b expected no conflict",
                       ifu_stall_o, ifu_flush_o, idu_stall_o, idu_flush_o, mem_timeout_o,
                       hazard_state_o);
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        #3;
        set_lu(5'd5);
        ex_pc_wr_en_i = 1'b1;
        #1 chk("rst_gate", O_IDLE);
        clear_inputs();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        cyc("post_rst", O_IDLE);

        // Load-use variants
        set_lu(5'd5);                       cyc("lu_rs1", O_LU);
        ex_rd_wr_en_i = 1'b0;               cyc("lu_after", O_IDLE);
        clear_inputs();
        ex_rd_wr_en_i = 1'b1; ex_rd_wr_sel_i = 2'b01; ex_rd_wr_addr_i = 5'd7;
        id_rs2_rd_addr_i = 5'd7; id_rs2_used_i = 1'b1;
        cyc("lu_rs2", O_LU);
        id_rs2_used_i = 1'b0;               cyc("lu_rs2_unused", O_IDLE);
        clear_inputs(); set_lu(5'd0);       cyc("lu_rd0", O_IDLE);
        set_lu(5'd9); ex_rd_wr_sel_i = 2'b00; cyc("lu_not_load", O_IDLE);
        clear_inputs();

        // Redirect with FLUSH_LEN=2; load-use suppressed inside FLUSH
        ex_pc_wr_en_i = 1'b1;               cyc("redir_t0", O_REDIR_RUN);
        ex_pc_wr_en_i = 1'b0; set_lu(5'd3); cyc("redir_t1", O_FLUSH);
        clear_inputs();                     cyc("redir_t2", O_FLUSH);
        cyc("redir_t3", O_IDLE);

        // DRAM wait, ack on third cycle
        dram_req_i = 1'b1;                  cyc("mw_c1", O_STALL_RUN);
        cyc("mw_c2", O_STALL_MW);
        dram_ack_i = 1'b1;                  cyc("mw_ack", O_MW_REL);
        clear_inputs();                     cyc("mw_after", O_IDLE);

        // MW + redirect + load-use together: stalls only, redirect follows release
        dram_req_i = 1'b1; ex_pc_wr_en_i = 1'b1; set_lu(5'd4);
        cyc("sim_c1", O_STALL_RUN);
        cyc("sim_c2", O_STALL_MW);
        dram_ack_i = 1'b1;                  cyc("sim_ack", O_MW_REL);
        dram_req_i = 1'b0; dram_ack_i = 1'b0;
        cyc("sim_redir", O_REDIR_RUN);
        ex_pc_wr_en_i = 1'b0;               cyc("sim_fl1", O_FLUSH);
        clear_inputs();                     cyc("sim_fl2", O_FLUSH);
        cyc("sim_run", O_IDLE);

        // DRAM wait inside FLUSH resumes the flush afterwards
        ex_pc_wr_en_i = 1'b1;               cyc("fmw_redir", O_REDIR_RUN);
        ex_pc_wr_en_i = 1'b0; dram_req_i = 1'b1;
        cyc("fmw_stall", O_STALL_FL);
        cyc("fmw_wait", O_STALL_MW);
        dram_ack_i = 1'b1;                  cyc("fmw_ack", O_MW_REL);
        clear_inputs();                     cyc("fmw_fl1", O_FLUSH);
        cyc("fmw_fl2", O_FLUSH);
        cyc("fmw_run", O_IDLE);

        // Redirect during FLUSH reloads the counter
        ex_pc_wr_en_i = 1'b1;               cyc("rl_redir", O_REDIR_RUN);
        ex_pc_wr_en_i = 1'b0;               cyc("rl_fl1", O_FLUSH);
        ex_pc_wr_en_i = 1'b1;               cyc("rl_reload", O_REDIR_FLUSH);
        ex_pc_wr_en_i = 1'b0;               cyc("rl_fl2", O_FLUSH);
        cyc("rl_fl3", O_FLUSH);
        cyc("rl_run", O_IDLE);

        // Timeout with WAIT_W=2: pulse on the 4th waiting cycle
        dram_req_i = 1'b1;                  cyc("to_c1", O_STALL_RUN);
        cyc("to_c2", O_STALL_MW);
        cyc("to_c3", O_STALL_MW);
        cyc("to_c4", O_TIMEOUT);
        clear_inputs();                     cyc("to_after", O_IDLE);

        // Asynchronous reset in the middle of a DRAM wait
        dram_req_i = 1'b1;                  cyc("rmw_c1", O_STALL_RUN);
        #1 chk("rmw_pre", O_STALL_MW);
        rst_i = 1'b1;
        #1 chk("rmw_async", O_IDLE);
        dram_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        cyc("rmw_rel", O_IDLE);
        dram_req_i = 1'b1;                  cyc("rmw_c1b", O_STALL_RUN);
        cyc("rmw_c2b", O_STALL_MW);
        cyc("rmw_c3b", O_STALL_MW);
        cyc("rmw_to", O_TIMEOUT);
        clear_inputs();                     cyc("rmw_after", O_IDLE);

        // Reset during FLUSH must clear the pending flush count
        ex_pc_wr_en_i = 1'b1;               cyc("rfl_redir", O_REDIR_RUN);
        ex_pc_wr_en_i = 1'b0;
        #1 chk("rfl_pre", O_FLUSH);
        rst_i = 1'b1;
        #1 chk("rfl_async", O_IDLE);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        cyc("rfl_rel", O_IDLE);
        dram_req_i = 1'b1;                  cyc("rfl_mw", O_STALL_RUN);
        dram_ack_i = 1'b1;                  cyc("rfl_ack", O_MW_REL);
        clear_inputs();                     cyc("rfl_run", O_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
